plic_target_arbiter: RTL and testbench

//  Interrupt gateway plus per-target priority arbiter for the SoC PLIC region. It serves NumSources level irqs
//  and NumTargets harts (M-mode, S-mode). It tracks pending/in-service state per source and picks the

---
 rtl/ariane_soc_pkg.sv | 16 +
 rtl/plic_prio_tree.sv | 23 ++
 rtl/plic_target_arbiter.sv | 106 ++++++++++
 tb/tb_plic_target_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_soc_pkg.sv
// Shared PLIC constants and the per-source gateway state type.
package ariane_soc;

  localparam int unsigned NumSources  = 30;
  localparam int unsigned NumTargets  = 2;
  localparam int unsigned MaxPriority = 7;
  localparam int unsigned PrioWidth   = $clog2(MaxPriority + 1);
  localparam int unsigned SrcIdWidth  = $clog2(NumSources + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gateway_state_e;

endpackage

// File: rtl/plic_prio_tree.sv
// Combinational finder of the highest-priority candidate source; lowest ID wins ties.
module plic_prio_tree
  import ariane_soc::*;
(
  input  logic [NumSources-1:0]                cand,
  input  logic [NumSources-1:0][PrioWidth-1:0] prio,
  output logic [SrcIdWidth-1:0]                best_id,
  output logic [PrioWidth-1:0]                 best_prio
);

  always_comb begin
    best_id   = '0;
    best_prio = '0;
    // Strict compare while scanning upward keeps the lowest ID on equal priority.
    for (int k = 0; k < NumSources; k++) begin
      if (cand[k] && (prio[k] > best_prio)) begin
        best_id   = SrcIdWidth'(k + 1);
        best_prio = prio[k];
      end
    end
  end

endmodule

// File: rtl/plic_target_arbiter.sv
// PLIC gateways plus per-target arbitration, irq generation and claim/complete sequencing.
module plic_target_arbiter
  import ariane_soc::*;
(
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumSources-1:0]                 irq_sources_i,
  input  logic [NumSources-1:0][PrioWidth-1:0]  prio_i,
  input  logic [NumTargets-1:0][NumSources-1:0] enable_i,
  input  logic [NumTargets-1:0][PrioWidth-1:0]  threshold_i,
  input  logic [NumTargets-1:0]                 claim_req_i,
  output logic [NumTargets-1:0]                 claim_valid_o,
  output logic [NumTargets-1:0][SrcIdWidth-1:0] claim_id_o,
  input  logic [NumTargets-1:0]                 complete_req_i,
  input  logic [NumTargets-1:0][SrcIdWidth-1:0] complete_id_i,
  output logic [NumTargets-1:0]                 irq_o,
  output logic [NumSources-1:0][1:0]            gw_state
);

  gateway_state_e gw_q [NumSources];
  gateway_state_e gw_d [NumSources];

  logic [NumSources-1:0]                 pending, prio_nz, claimed_now, completed;
  logic [NumTargets-1:0][SrcIdWidth-1:0] best_id_q, tree_id;
  logic [NumTargets-1:0][PrioWidth-1:0]  tree_prio;
  logic [NumTargets-1:0]                 irq_q, grant, best_pending;

  always_comb begin
    for (int k = 0; k < NumSources; k++) begin
      pending[k]  = (gw_q[k] == PENDING);
      prio_nz[k]  = |prio_i[k];
      gw_state[k] = gw_q[k];
    end
  end

  for (genvar t = 0; t < NumTargets; t++) begin : g_tree
    plic_prio_tree u_tree (
      .cand      (pending & enable_i[t] & prio_nz),
      .prio      (prio_i),
      .best_id   (tree_id[t]),
      .best_prio (tree_prio[t])
    );
  end

  // Handshake: claim_req_i is a 1-cycle strobe; claim_valid_o pulses one cycle later with
  // claim_id_o (0 = nothing). complete_req_i is a 1-cycle strobe qualified by complete_id_i.
  // A grant rechecks that the registered best is still pending, and a lower-index target
  // wins when two targets grant the same ID in one cycle.
  always_comb begin
    grant        = '0;
    best_pending = '0;
    for (int t = 0; t < NumTargets; t++) begin
      for (int k = 0; k < NumSources; k++) begin
        if (best_id_q[t] == SrcIdWidth'(k + 1)) best_pending[t] = pending[k];
      end
      grant[t] = claim_req_i[t] & irq_q[t] & best_pending[t];
      for (int u = 0; u < t; u++) begin
        if (grant[u] && (best_id_q[u] == best_id_q[t])) grant[t] = 1'b0;
      end
    end
  end

  always_comb begin
    claimed_now = '0;
    completed   = '0;
    for (int k = 0; k < NumSources; k++) begin
      for (int t = 0; t < NumTargets; t++) begin
        if (grant[t] && (best_id_q[t] == SrcIdWidth'(k + 1)))                claimed_now[k] = 1'b1;
        if (complete_req_i[t] && (complete_id_i[t] == SrcIdWidth'(k + 1))) completed[k]   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumSources; k++) begin
      gw_d[k] = gw_q[k];
      case (gw_q[k])
        IDLE:    if (irq_sources_i[k]) gw_d[k] = PENDING;
        PENDING: if (claimed_now[k])   gw_d[k] = CLAIMED;
        CLAIMED: if (completed[k])     gw_d[k] = IDLE;
        default: gw_d[k] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumSources; k++) gw_q[k] <= IDLE;
      best_id_q     <= '0;
      irq_q         <= '0;
      claim_valid_o <= '0;
      claim_id_o    <= '0;
    end else begin
      for (int k = 0; k < NumSources; k++) gw_q[k] <= gw_d[k];
      best_id_q     <= tree_id;
      claim_valid_o <= claim_req_i;
      for (int t = 0; t < NumTargets; t++) begin
        irq_q[t] <= (tree_prio[t] > threshold_i[t]);
        if (claim_req_i[t]) claim_id_o[t] <= grant[t] ? best_id_q[t] : '0;
      end
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_plic_target_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural PLIC model.
module tb_plic_target_arbiter;
  import ariane_soc::*;

  logic                                  clk = 1'b0;
  logic                                  rst_n;
  logic [NumSources-1:0]                 irq_src;
  logic [NumSources-1:0][PrioWidth-1:0]  prio;
  logic [NumTargets-1:0][NumSources-1:0] en;
  logic [NumTargets-1:0][PrioWidth-1:0]  thr;
  logic [NumTargets-1:0]                 claim_req, claim_valid, complete_req, irq;
  logic [NumTargets-1:0][SrcIdWidth-1:0] claim_id, complete_id;
  logic [NumSources-1:0][1:0]            gw_state;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  plic_target_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .irq_sources_i  (irq_src),
    .prio_i         (prio),
    .enable_i       (en),
    .threshold_i    (thr),
    .claim_req_i    (claim_req),
    .claim_valid_o  (claim_valid),
    .claim_id_o     (claim_id),
    .complete_req_i (complete_req),
    .complete_id_i  (complete_id),
    .irq_o          (irq),
    .gw_state       (gw_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  gateway_state_e m_st [0:NumSources];
  int             m_best [NumTargets];
  int             m_cid  [NumTargets];
  bit             m_irq  [NumTargets];
  bit             m_cv   [NumTargets];

  always @(posedge clk) begin : model
    gateway_state_e nst [0:NumSources];
    bit g [NumTargets];
    int maxp;
    if (!rst_n) begin
      for (int s = 0; s <= NumSources; s++) m_st[s] = IDLE;
      for (int t = 0; t < NumTargets; t++) begin
        m_best[t] = 0; m_cid[t] = 0; m_irq[t] = 1'b0; m_cv[t] = 1'b0;
      end
    end else begin
      for (int s = 0; s <= NumSources; s++) nst[s] = m_st[s];
      for (int t = 0; t < NumTargets; t++) begin
        g[t] = claim_req[t] && m_irq[t] && (m_best[t] != 0) && (m_st[m_best[t]] == PENDING);
        for (int u = 0; u < t; u++)
          if (g[u] && m_best[u] == m_best[t]) g[t] = 1'b0;
      end
      for (int t = 0; t < NumTargets; t++) begin
        m_cv[t] = claim_req[t];
        if (claim_req[t]) m_cid[t] = g[t] ? m_best[t] : 0;
        if (g[t]) nst[m_best[t]] = CLAIMED;
      end
      // Best = maximum priority among enabled pending sources, then the smallest ID holding it.
      for (int t = 0; t < NumTargets; t++) begin
        maxp = 0;
        for (int s = 1; s <= NumSources; s++)
          if (m_st[s] == PENDING && en[t][s-1] && int'(prio[s-1]) > maxp) maxp = int'(prio[s-1]);
        m_best[t] = 0;
        if (maxp > 0)
          for (int s = NumSources; s >= 1; s--)
            if (m_st[s] == PENDING && en[t][s-1] && int'(prio[s-1]) == maxp) m_best[t] = s;
        m_irq[t] = (maxp > int'(thr[t]));
      end
      for (int s = 1; s <= NumSources; s++) begin
        if (m_st[s] == CLAIMED) begin
          for (int t = 0; t < NumTargets; t++)
            if (complete_req[t] && int'(complete_id[t]) == s) nst[s] = IDLE;
        end else if (m_st[s] == IDLE && irq_src[s-1]) begin
          nst[s] = PENDING;
        end
      end
      for (int s = 0; s <= NumSources; s++) m_st[s] = nst[s];
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int t = 0; t < NumTargets; t++) begin
        chk($sformatf("irq[%0d]", t), int'(irq[t]), int'(m_irq[t]));
        chk($sformatf("claim_valid[%0d]", t), int'(claim_valid[t]), int'(m_cv[t]));
        chk($sformatf("claim_id[%0d]", t), int'(claim_id[t]), m_cid[t]);
      end
      for (int s = 1; s <= NumSources; s++)
        chk($sformatf("state[%0d]", s), int'(gw_state[s-1]), int'(m_st[s]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    irq_src = '0; prio = '0; en = '0; thr = '0;
    claim_req = '0; complete_req = '0; complete_id = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic claim(input logic [NumTargets-1:0] mask);
    claim_req = mask;
    tick();
    claim_req = '0;
  endtask

  task automatic complete(input int t, input int id);
    complete_req[t] = 1'b1;
    complete_id[t]  = SrcIdWidth'(id);
    tick();
    complete_req = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cl[$];
    clear_inputs();
    rst_n = 1'b0;
    tick(2);
    chk_en = 1'b1;
    chk("reset_irq", int'(irq), 0);
    chk("reset_claim_id", int'(claim_id), 0);
    rst_n = 1'b1;

    // Single source: irq two cycles after line rise, claim, drop.
    prio[4] = 3'd3; en[0][4] = 1'b1; irq_src[4] = 1'b1;
    tick();
    chk("t1_irq_c1", int'(irq[0]), 0);
    tick();
    chk("t1_irq_c2", int'(irq[0]), 1);
    chk("t1_model_irq", int'(m_irq[0]), 1);
    claim(2'b01);
    irq_src[4] = 1'b0;
    chk("t1_valid", int'(claim_valid[0]), 1);
    chk("t1_id", int'(claim_id[0]), 5);
    chk("t1_model_id", m_cid[0], 5);
    tick();
    chk("t1_irq_drop", int'(irq[0]), 0);
    chk("t1_id_hold", int'(claim_id[0]), 5);
    complete(0, 5);
    tick();

    // Priority order with tie on lowest ID, then threshold masking.
    reset_dut();
    prio[2] = 3'd2; prio[8] = 3'd6; prio[3] = 3'd6;
    en[0][2] = 1'b1; en[0][8] = 1'b1; en[0][3] = 1'b1;
    irq_src[2] = 1'b1; irq_src[8] = 1'b1; irq_src[3] = 1'b1;
    tick();
    irq_src = '0;
    tick();
    chk("t2_irq", int'(irq[0]), 1);
    claim(2'b01);
    chk("t2_first", int'(claim_id[0]), 4);
    tick();
    claim(2'b01);
    chk("t2_second", int'(claim_id[0]), 9);
    tick();
    claim(2'b01);
    chk("t2_third", int'(claim_id[0]), 3);
    complete_req = 2'b11; complete_id[0] = 5'd4; complete_id[1] = 5'd9;
    tick();
    complete_req = '0;
    complete(0, 3);
    thr[0] = 3'd6; irq_src[8] = 1'b1; irq_src[3] = 1'b1;
    tick();
    irq_src = '0;
    tick(2);
    chk("t2_thr_mask", int'(irq[0]), 0);
    claim(2'b01);
    chk("t2_masked_valid", int'(claim_valid[0]), 1);
    chk("t2_masked_id", int'(claim_id[0]), 0);
    thr[0] = 3'd5;
    tick();
    chk("t2_thr_below", int'(irq[0]), 1);

    // Both targets claim the same source in one cycle.
    reset_dut();
    prio[6] = 3'd1; en[0][6] = 1'b1; en[1][6] = 1'b1; irq_src[6] = 1'b1;
    tick(2);
    chk("t3_irq", int'(irq), 3);
    claim(2'b11);
    chk("t3_valid", int'(claim_valid), 3);
    chk("t3_id_t0", int'(claim_id[0]), 7);
    chk("t3_id_t1", int'(claim_id[1]), 0);
    chk("t3_claimed", int'(gw_state[6]), int'(CLAIMED));

    // Line held high while claimed: no re-pend until complete.
    tick(3);
    chk("t4_irq_low", int'(irq), 0);
    chk("t4_still_claimed", int'(gw_state[6]), int'(CLAIMED));
    complete(1, 7);
    chk("t4_idle", int'(gw_state[6]), int'(IDLE));
    tick();
    chk("t4_repend", int'(gw_state[6]), int'(PENDING));
    chk("t4_irq_not_yet", int'(irq), 0);
    tick();
    chk("t4_irq_back", int'(irq), 3);

    // Completes that must be ignored: ID 0, ID 31, idle ID, pending ID.
    complete_req = 2'b11; complete_id[0] = 5'd0; complete_id[1] = 5'd31;
    tick();
    complete_req = '0;
    complete(0, 12);
    complete(1, 7);
    chk("t5_pending_kept", int'(gw_state[6]), int'(PENDING));
    chk("t5_idle_kept", int'(gw_state[11]), int'(IDLE));
    chk("t5_irq", int'(irq), 3);

    // Reset in the middle of a claimed/pending mix.
    reset_dut();
    prio[1] = 3'd5; prio[7] = 3'd2; en[0][1] = 1'b1; en[0][7] = 1'b1;
    irq_src[1] = 1'b1; irq_src[7] = 1'b1;
    tick();
    irq_src[1] = 1'b0;
    tick();
    claim(2'b01);
    chk("t6_pre_id", int'(claim_id[0]), 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_rst_irq", int'(irq), 0);
    chk("t6_rst_valid", int'(claim_valid), 0);
    chk("t6_rst_id", int'(claim_id[0]), 0);
    chk("t6_rst_state", int'(gw_state[7]), int'(IDLE));
    tick();
    chk("t6_repend", int'(gw_state[7]), int'(PENDING));
    tick();
    chk("t6_irq_back", int'(irq[0]), 1);

    // Randomized traffic checked by the model each cycle.
    reset_dut();
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        for (int s = 0; s < NumSources; s++) prio[s] = PrioWidth'($urandom_range(0, MaxPriority));
        for (int t = 0; t < NumTargets; t++) begin
          en[t]  = NumSources'($urandom);
          thr[t] = PrioWidth'($urandom_range(0, 3));
        end
      end else if ($urandom_range(0, 19) == 0) begin
        prio[$urandom_range(0, NumSources - 1)] = PrioWidth'($urandom_range(0, MaxPriority));
        thr[$urandom_range(0, NumTargets - 1)]  = PrioWidth'($urandom_range(0, MaxPriority));
      end
      for (int s = 0; s < NumSources; s++)
        if ($urandom_range(0, 9) == 0) irq_src[s] = ~irq_src[s];
      cl.delete();
      for (int s = 1; s <= NumSources; s++) if (m_st[s] == CLAIMED) cl.push_back(s);
      for (int t = 0; t < NumTargets; t++) begin
        claim_req[t]    = ($urandom_range(0, 3) == 0);
        complete_req[t] = ($urandom_range(0, 2) == 0);
        if (cl.size() > 0 && $urandom_range(0, 9) < 7)
          complete_id[t] = SrcIdWidth'(cl[$urandom_range(0, cl.size() - 1)]);
        else
          complete_id[t] = SrcIdWidth'($urandom_range(0, 31));
      end
      rst_n = ($urandom_range(0, 999) != 0);
      tick();
    end
    clear_inputs();
    rst_n = 1'b1;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
